// File: rtl/cnn_window_gen_pkg.sv
// Shared types, sizes and helpers for the CNN sliding-window generator.
package cnn_window_gen_pkg;

  localparam int DW          = 32;   // pixel / window lane width
  localparam int KMAX        = 3;    // largest kernel side
  localparam int MAX_IMG_W   = 64;   // line-buffer depth
  localparam int DIM_W       = 8;    // image dimension field width
  localparam int WINDOW_SIZE = KMAX * KMAX;
  localparam int KERNEL_SIZE = KMAX;
  localparam int LB_AW       = $clog2(MAX_IMG_W);
  localparam int SIDE_W      = $clog2(KMAX + 1);

  typedef logic [DW-1:0]          pix_t;
  typedef logic [DIM_W-1:0]       dim_t;
  typedef logic [KERNEL_SIZE-1:0] ksel_t;
  typedef logic [SIDE_W-1:0]      side_t;

  // Lane i sits at bits [i*DW +: DW].
  typedef logic [WINDOW_SIZE-1:0][DW-1:0] win_t;

  // Column shift registers: entry [r][c] holds pixel(row-KMAX+1+r, col-KMAX+1+c).
  typedef logic [KMAX-1:0][KMAX-1:0][DW-1:0] sr_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // One-hot kernel side select; the highest set bit wins and all-zero means side 1.
  function automatic side_t decode_side(ksel_t k);
    side_t s;
    s = side_t'(1);
    for (int i = 0; i < KMAX; i++) begin
      if (k[i]) s = side_t'(i + 1);
    end
    return s;
  endfunction

  // Pick the bottom-right kh x kw corner of the shift registers, packed row-major;
  // lanes beyond kh*kw stay zero.
  function automatic win_t build_window(sr_t sr, side_t kh, side_t kw);
    win_t w;
    w = '0;
    for (int h = 1; h <= KMAX; h++) begin
      for (int v = 1; v <= KMAX; v++) begin
        if (side_t'(h) == kh && side_t'(v) == kw) begin
          for (int r = 0; r < h; r++) begin
            for (int c = 0; c < v; c++) begin
              w[r*v + c] = sr[KMAX-h+r][KMAX-v+c];
            end
          end
        end
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/cnn_window_gen_if.sv
// Pixel-stream input and window output of the window generator, bundled together.
interface cnn_window_gen_if;
  import cnn_window_gen_pkg::*;

  logic pix_valid;
  pix_t pix_data;
  logic pix_ready;
  logic window_stall;
  logic window_valid;
  win_t window;

  // Window generator side: consumes pixels, produces windows.
  modport master (
    input  pix_valid, pix_data, window_stall,
    output pix_ready, window_valid, window
  );

  // Environment side: feature-map reader plus convolution engine.
  modport slave (
    output pix_valid, pix_data, window_stall,
    input  pix_ready, window_valid, window
  );
endinterface

// File: rtl/cnn_line_buffer.sv
// One image row of storage: combinational read and registered write at the same
// address, so a read returns the value from the previous row (read-before-write).
module cnn_line_buffer #(
  parameter int DW    = 32,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  // Write the incoming row element over the one just read out.
  // NOTE: storage is deliberately not reset; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/cnn_window_gen.sv
// Sliding-window producer: buffers KMAX-1 rows of a raster pixel stream and emits
// one kernel-sized window per pixel whose window lies fully inside the image.
module cnn_window_gen
  import cnn_window_gen_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             conf_refresh,
  input  ksel_t            kernel_height,
  input  ksel_t            kernel_width,
  input  dim_t             img_width,
  input  dim_t             img_height,
  cnn_window_gen_if.master bus,
  output logic             busy,
  output logic             frame_done
);

  state_t state_q, state_d;
  side_t  kh_q, kh_d, kw_q, kw_d;
  dim_t   img_w_q, img_w_d, img_h_q, img_h_d;
  dim_t   row_q, row_d, col_q, col_d;
  sr_t    sr_q, sr_d, sr_shift;
  win_t   win_q, win_d;
  logic   win_valid_q, win_valid_d;
  logic   frame_done_q, frame_done_d;

  logic accept, emit, last_col, last_pix;
  logic [KMAX-1:0][DW-1:0] col_new;
  logic [KMAX-2:0][DW-1:0] lb_rd;

  // An abort request wins over a pixel offered in the same cycle.
  assign accept   = (state_q == RUN) && !conf_refresh && !bus.window_stall && bus.pix_valid;
  assign last_col = (col_q == img_w_q - DIM_W'(1));
  assign last_pix = last_col && (row_q == img_h_q - DIM_W'(1));
  assign emit     = (row_q >= DIM_W'(kh_q) - DIM_W'(1)) && (col_q >= DIM_W'(kw_q) - DIM_W'(1));

  assign bus.pix_ready    = (state_q == RUN) && !bus.window_stall;
  assign bus.window_valid = win_valid_q;
  assign bus.window       = win_q;
  assign busy             = (state_q != IDLE);
  assign frame_done       = frame_done_q;

  // Line buffer 0 holds the previous row; each deeper buffer takes what the one
  // above it just read out, so buffer b holds row-(b+1).
  for (genvar b = 0; b < KMAX-1; b++) begin : g_lb
    logic [DW-1:0] wdata;
    if (b == 0) begin : g_head
      assign wdata = bus.pix_data;
    end else begin : g_chain
      assign wdata = lb_rd[b-1];
    end
    cnn_line_buffer #(.DW(DW), .DEPTH(MAX_IMG_W), .AW(LB_AW)) u_lb (
      .clk     (clk),
      .we_i    (accept),
      .addr_i  (col_q[LB_AW-1:0]),
      .wdata_i (wdata),
      .rdata_o (lb_rd[b])
    );
  end

  // Build the column entering the window and the shift registers after shifting it in.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    col_new  = '0;
    sr_shift = '0;
    col_new[KMAX-1] = bus.pix_data;
    for (int b = 0; b < KMAX-1; b++) col_new[KMAX-2-b] = lb_rd[b];
    for (int r = 0; r < KMAX; r++) begin
      for (int c = 0; c < KMAX-1; c++) sr_shift[r][c] = sr_q[r][c+1];
      sr_shift[r][KMAX-1] = col_new[r];
    end
  end

  // Next-state logic: frame control, raster counters and the registered window.
  always_comb begin
    state_d      = state_q;
    kh_d         = kh_q;
    kw_d         = kw_q;
    img_w_d      = img_w_q;
    img_h_d      = img_h_q;
    row_d        = row_q;
    col_d        = col_q;
    sr_d         = sr_q;
    win_valid_d  = win_valid_q;
    win_d        = win_q;
    frame_done_d = 1'b0;

    if (conf_refresh) begin
      // Start (or restart) a frame from any state; an aborted frame never reports done.
      state_d     = RUN;
      kh_d        = decode_side(kernel_height);
      kw_d        = decode_side(kernel_width);
      img_w_d     = img_width;
      img_h_d     = img_height;
      row_d       = '0;
      col_d       = '0;
      sr_d        = '0;
      win_valid_d = 1'b0;
      win_d       = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        RUN: begin
          // While stalled everything holds; otherwise the current window is consumed.
          if (!bus.window_stall) begin
            win_valid_d = 1'b0;
            win_d       = '0;
            if (accept) begin
              sr_d = sr_shift;
              if (emit) begin
                win_valid_d = 1'b1;
                win_d       = build_window(sr_shift, kh_q, kw_q);
              end
              if (last_col) begin
                col_d = '0;
                row_d = row_q + DIM_W'(1);
              end else begin
                col_d = col_q + DIM_W'(1);
              end
              if (last_pix) state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          // Finish once the final window (if any) has been taken.
          if (!win_valid_q || !bus.window_stall) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
            win_valid_d  = 1'b0;
            win_d        = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q      <= IDLE;
      kh_q         <= side_t'(1);
      kw_q         <= side_t'(1);
      img_w_q      <= '0;
      img_h_q      <= '0;
      row_q        <= '0;
      col_q        <= '0;
      sr_q         <= '0;
      win_valid_q  <= 1'b0;
      win_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      kh_q         <= kh_d;
      kw_q         <= kw_d;
      img_w_q      <= img_w_d;
      img_h_q      <= img_h_d;
      row_q        <= row_d;
      col_q        <= col_d;
      sr_q         <= sr_d;
      win_valid_q  <= win_valid_d;
      win_q        <= win_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
